// File: rtl/sparc_pkg.sv
// ============================================================================
// Module      : sparc_pkg
// Description : Shared fetch-stage types: FSM states, trap codes, RAM opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [2:0] TRAP_NONE     = 3'd0;
    localparam logic [2:0] TRAP_MISALIGN = 3'd1;
    localparam logic [2:0] TRAP_IACCESS  = 3'd2;

    localparam logic [5:0] RAM_OP_RD_WORD = 6'b000000;

endpackage

`default_nettype wire

// File: rtl/pc_npc_regs.sv
// ============================================================================
// Module      : pc_npc_regs
// Description : PC/NPC pair with delayed-branch advance (PC<=NPC, NPC<=target
//               or NPC+4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_npc_regs #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    input  logic              i_branch_sel,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_npc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= '0;
            r_npc <= ADDR_W'(4);
        end else if (i_advance) begin
            r_pc  <= r_npc;
            r_npc <= i_branch_sel ? i_branch_target : r_npc + ADDR_W'(4);
        end
    end

    assign o_pc  = r_pc;
    assign o_npc = r_npc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch FSM with MFC handshake, IR load pulse and trap reporting.
//               Define FETCH_TIMEOUT_EN to enable the MFC wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import sparc_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [5:0]  RAM_RD_WORD = RAM_OP_RD_WORD,
    parameter int          TIMEOUT     = 15
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              fetch_start,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              MFC,
    input  logic [31:0]       mem_data,
    output logic              RAM_enable,
    output logic [5:0]        RAM_OpCode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       IR_In,
    output logic              IR_Enable,
    output logic [ADDR_W-1:0] PC_out,
    output logic [ADDR_W-1:0] NPC_out,
    output logic              busy,
    output logic              fetch_trap,
    output logic [2:0]        trap_code
);

    fetch_state_t      r_state;
    logic              r_br_taken;
    logic [ADDR_W-1:0] r_br_target;
    logic              w_advance;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
`else
    wire w_unused_timeout = (TIMEOUT != 0);
`endif

    assign w_advance = (r_state == ST_LOAD);

    pc_npc_regs #(
        .ADDR_W (ADDR_W)
    ) u_pc_npc_regs (
        .clk             (Clk),
        .rst             (RESET),
        .i_advance       (w_advance),
        .i_branch_sel    (r_br_taken),
        .i_branch_target (r_br_target),
        .o_pc            (PC_out),
        .o_npc           (NPC_out)
    );

    // All outputs are registered on the state transition that enters the
    // state they belong to, so each is valid for exactly that state's cycle.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            RAM_enable  <= 1'b0;
            RAM_OpCode  <= '0;
            mem_addr    <= '0;
            IR_In       <= '0;
            IR_Enable   <= 1'b0;
            busy        <= 1'b0;
            fetch_trap  <= 1'b0;
            trap_code   <= TRAP_NONE;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            IR_Enable  <= 1'b0;
            fetch_trap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        r_br_taken  <= branch_taken;
                        r_br_target <= branch_target;
                        busy        <= 1'b1;
                        if (PC_out[1:0] != 2'b00) begin
                            trap_code  <= TRAP_MISALIGN;
                            fetch_trap <= 1'b1;
                            r_state    <= ST_FAULT;
                        end else begin
                            trap_code  <= TRAP_NONE;
                            RAM_enable <= 1'b1;
                            RAM_OpCode <= RAM_RD_WORD;
                            mem_addr   <= PC_out;
                            r_state    <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
`ifdef FETCH_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (MFC) begin
                        IR_In      <= mem_data;
                        IR_Enable  <= 1'b1;
                        RAM_enable <= 1'b0;
                        RAM_OpCode <= '0;
                        r_state    <= ST_LOAD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        RAM_enable <= 1'b0;
                        RAM_OpCode <= '0;
                        trap_code  <= TRAP_IACCESS;
                        fetch_trap <= 1'b1;
                        r_state    <= ST_FAULT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                ST_LOAD: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit against an
//               architectural PC/NPC/IR reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;

    logic              Clk = 1'b0;
    logic              RESET = 1'b1;
    logic              fetch_start = 1'b0;
    logic              branch_taken = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic              MFC = 1'b0;
    logic [31:0]       mem_data;
    logic              RAM_enable;
    logic [5:0]        RAM_OpCode;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       IR_In;
    logic              IR_Enable;
    logic [ADDR_W-1:0] PC_out;
    logic [ADDR_W-1:0] NPC_out;
    logic              busy;
    logic              fetch_trap;
    logic [2:0]        trap_code;

    logic [31:0] ram [256];
    assign mem_data = ram[mem_addr[9:2]];

    // Architectural reference state
    logic [31:0] m_pc, m_npc, m_ir;
    logic [2:0]  m_tc;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .RAM_RD_WORD (6'b000000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .fetch_start   (fetch_start),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .MFC           (MFC),
        .mem_data      (mem_data),
        .RAM_enable    (RAM_enable),
        .RAM_OpCode    (RAM_OpCode),
        .mem_addr      (mem_addr),
        .IR_In         (IR_In),
        .IR_Enable     (IR_Enable),
        .PC_out        (PC_out),
        .NPC_out       (NPC_out),
        .busy          (busy),
        .fetch_trap    (fetch_trap),
        .trap_code     (trap_code)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        fetch_start = 1'b0;
        MFC = 1'b0;
        repeat (2) @(posedge Clk);
        #1 RESET = 1'b0;
        m_pc = 32'd0; m_npc = 32'd4; m_ir = 32'd0; m_tc = 3'd0;
    endtask

    // One fetch; k = cycles MFC is late relative to the first WAIT cycle.
    task automatic do_fetch(input logic taken, input logic [31:0] tgt, input int k);
        logic mis;
        mis = (m_pc[1:0] != 2'b00);
        @(posedge Clk);
        #1 fetch_start = 1'b1; branch_taken = taken; branch_target = tgt;
        @(negedge Clk);
        chk("idle_busy", busy, 0);
        @(posedge Clk);
        #1 fetch_start = 1'b0; branch_taken = 1'($urandom); branch_target = $urandom;
        @(negedge Clk);
        chk("start_busy", busy, 1);
        if (mis) begin
            m_tc = 3'd1;
            chk("mis_trap", fetch_trap, 1);
            chk("mis_code", trap_code, m_tc);
            chk("mis_ram_en", RAM_enable, 0);
            chk("mis_pc", PC_out, m_pc);
            @(negedge Clk);
            chk("mis_trap_end", fetch_trap, 0);
            chk("mis_ram_en2", RAM_enable, 0);
            chk("mis_code_hold", trap_code, m_tc);
            chk("mis_pc_hold", PC_out, m_pc);
            chk("mis_npc_hold", NPC_out, m_npc);
            chk("mis_ir_hold", IR_In, m_ir);
            chk("mis_idle", busy, 0);
            return;
        end
        m_tc = 3'd0;
        chk("req_ram_en", RAM_enable, 1);
        chk("req_addr", mem_addr, m_pc);
        chk("req_op", RAM_OpCode, 0);
        chk("req_code", trap_code, m_tc);
        @(posedge Clk);
        for (int j = 0; j < k; j++) begin
            @(negedge Clk);
            chk("wait_ram_en", RAM_enable, 1);
            chk("wait_ir_en", IR_Enable, 0);
            @(posedge Clk);
        end
        #1 MFC = 1'b1;
        @(posedge Clk);
        #1 MFC = 1'b0;
        @(negedge Clk);
        m_ir = ram[m_pc[9:2]];
        chk("load_ir_en", IR_Enable, 1);
        chk("load_ir", IR_In, m_ir);
        chk("load_ram_en", RAM_enable, 0);
        m_pc  = m_npc;
        m_npc = taken ? tgt : m_npc + 32'd4;
        @(negedge Clk);
        chk("post_ir_en", IR_Enable, 0);
        chk("post_busy", busy, 0);
        chk("post_pc", PC_out, m_pc);
        chk("post_npc", NPC_out, m_npc);
        chk("post_ir", IR_In, m_ir);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[0] = 32'h8200_2003;

        // Reset state
        reset_dut();
        @(negedge Clk);
        chk("rst_pc", PC_out, 0);
        chk("rst_npc", NPC_out, 4);
        chk("rst_ir_en", IR_Enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ir", IR_In, 0);
        chk("rst_code", trap_code, 0);

        // First word at address 0, MFC two cycles late
        do_fetch(1'b0, 32'h0, 2);

        // Delayed branch
        reset_dut();
        do_fetch(1'b1, 32'h40, 1);
        do_fetch(1'b0, 32'h0, 0);
        chk("dly_pc", PC_out, 32'h40);
        chk("dly_npc", NPC_out, 32'h44);

        // Misaligned target reaching PC
        reset_dut();
        do_fetch(1'b1, 32'h6, 0);
        do_fetch(1'b0, 32'h0, 3);
        chk("mis_pc_is6", PC_out, 32'h6);
        do_fetch(1'b0, 32'h0, 0);
        do_fetch(1'b1, 32'h100, 0);

        // Reset while waiting for MFC, then a late MFC
        reset_dut();
        do_fetch(1'b0, 32'h0, 0);
        @(posedge Clk); #1 fetch_start = 1'b1;
        @(posedge Clk); #1 fetch_start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3 RESET = 1'b1;
        #1;
        chk("arst_pc", PC_out, 0);
        chk("arst_npc", NPC_out, 4);
        chk("arst_ir", IR_In, 0);
        chk("arst_ram_en", RAM_enable, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_busy", busy, 0);
        @(posedge Clk);
        #1 RESET = 1'b0; MFC = 1'b1;
        m_pc = 32'd0; m_npc = 32'd4; m_ir = 32'd0;
        for (int j = 0; j < 6; j++) begin
            @(negedge Clk);
            chk("late_mfc_ir_en", IR_Enable, 0);
            chk("late_mfc_busy", busy, 0);
        end
        MFC = 1'b0;

        // Continuous fetch_start with MFC always high
        reset_dut();
        MFC = 1'b1;
        @(posedge Clk);
        #1 fetch_start = 1'b1; branch_taken = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clk);
            chk("b2b_pulse", IR_Enable, (c % 4 == 3) ? 1 : 0);
            if (c % 4 == 3) begin
                chk("b2b_pc", PC_out, 32'(4 * (c / 4)));
                chk("b2b_ir", IR_In, ram[c / 4]);
            end
        end
        fetch_start = 1'b0;
        MFC = 1'b0;

        // Randomized fetch sequence
        reset_dut();
        for (int n = 0; n < 16; n++) begin
            logic        tk;
            logic [31:0] tg;
            tk = ($urandom_range(0, 2) == 0);
            tg = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            do_fetch(tk, tg, int'($urandom_range(0, 4)));
        end

        // MFC never arrives
        reset_dut();
        @(posedge Clk); #1 fetch_start = 1'b1;
        @(posedge Clk); #1 fetch_start = 1'b0;
        @(posedge Clk);
`ifdef FETCH_TIMEOUT_EN
        for (int j = 0; j < TIMEOUT; j++) begin
            @(negedge Clk);
            chk("tmo_wait_ram_en", RAM_enable, 1);
            chk("tmo_wait_trap", fetch_trap, 0);
            @(posedge Clk);
        end
        @(negedge Clk);
        chk("tmo_trap", fetch_trap, 1);
        chk("tmo_code", trap_code, 2);
        chk("tmo_ram_en", RAM_enable, 0);
        chk("tmo_pc", PC_out, 0);
        @(negedge Clk);
        chk("tmo_trap_end", fetch_trap, 0);
        chk("tmo_code_hold", trap_code, 2);
`else
        for (int j = 0; j < 3 * TIMEOUT; j++) begin
            @(negedge Clk);
            chk("hold_ram_en", RAM_enable, 1);
            chk("hold_trap", fetch_trap, 0);
            chk("hold_code", trap_code, 0);
        end
`endif
        reset_dut();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage that sits directly upstream of the IR/DataPath. It owns PC/NPC sequencing with SPARC V8 delayed-branch semantics and reads one 32-bit instruction word from RAM through the MFC handshake. It then presents the word on `IR_In` with a single-cycle `IR_Enable` pulse. Fetch faults (misaligned PC, optional memory timeout) are reported to the ControlUnit as a trap code.

## Interface
- `ADDR_W`, 32: PC/NPC and RAM address width.
- `RAM_RD_WORD`, 6'b000000: RAM_OpCode value for a 32-bit word read.
- `TIMEOUT`, 15: maximum wait cycles for MFC (used only with timeout enabled).
- `Clk`  input  1: single system clock, rising edge.
- `RESET`  input  1: asynchronous, active-high reset.
- `fetch_start`  input  1: ControlUnit request to fetch the next instruction; sampled only in IDLE.
- `branch_taken`  input  1: sampled with `fetch_start`; selects `branch_target` as the new NPC.
- `branch_target`  input  ADDR_W: CTI target address.
- `MFC`  input  1: memory function complete from RAM.
- `mem_data`  input  32: RAM read data; valid when MFC=1.
- `RAM_enable`  output  1: RAM access strobe.
- `RAM_OpCode`  output  6: driven as RAM_RD_WORD during an access, otherwise 0.
- `mem_addr`  output  ADDR_W: address of the current fetch, equal to PC.
- `IR_In`  output  32: fetched instruction word.
- `IR_Enable`  output  1: one-cycle load pulse to the IR.
- `PC_out`, `NPC_out`  output  ADDR_W: architectural PC and NPC.
- `busy`  output  1: high in every state other than IDLE.
- `fetch_trap`  output  1: one-cycle trap pulse.
- `trap_code`  output  3: 0 = none, 1 = mem_address_not_aligned, 2 = instruction_access_exception; held until the next fetch_start.

## Operation
- Reset values: PC=0, NPC=4, IR_In=0, IR_Enable=0, RAM_enable=0, RAM_OpCode=0, mem_addr=0, busy=0, fetch_trap=0, trap_code=0, state=IDLE.
- IDLE: on `fetch_start`:
  - If PC[1:0] != 0: go to FAULT with trap_code=1.
  - Otherwise go to REQ.
  - Latch `branch_taken`/`branch_target` in both cases.
  - trap_code is cleared to 0 on the start of every new fetch.
- REQ: RAM_enable=1, mem_addr=PC, RAM_OpCode=RAM_RD_WORD. Go to WAIT.
- WAIT: hold RAM_enable and address.
  - On MFC=1: capture `mem_data` into IR_In and go to LOAD.
- LOAD:
  - IR_Enable=1 for exactly this cycle; RAM_enable=0.
  - PC <= NPC.
  - NPC <= latched branch_taken ? latched branch_target : NPC + 4.
  - Go to IDLE.
- FAULT:
  - fetch_trap=1 for exactly this cycle.
  - PC and NPC are unchanged and IR_In is unchanged.
  - Go to IDLE.
- `fetch_start` outside IDLE is ignored and not queued.
- NPC+4 wraps modulo 2^ADDR_W.
- Branch target alignment is not checked at latch time; a misaligned target faults when it reaches PC.
- MFC outside WAIT is ignored.
- RESET asserted mid-fetch:
  - Immediately forces the reset values.
  - Any late MFC is ignored, and no IR_Enable pulse is produced.

## Timing
- Aligned fetch with MFC arriving k cycles after entering WAIT (k ≥ 0, where k = 0 means MFC is already high on the first WAIT cycle):
  - IR_Enable pulses k+3 cycles after the fetch_start edge.
  - The IR holds the word from the following edge on.
- Misaligned fetch: fetch_trap pulses in the cycle after fetch_start; no RAM access occurs.
- fetch_start and MFC are registered inputs; there are no combinational input-to-output paths except the state-decoded outputs.
- Back-to-back fetches: fetch_start can be accepted in the cycle after LOAD, giving a minimum of 4 cycles per instruction.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without MFC: RAM_enable drops, trap_code=2, and the block goes to FAULT. PC is unchanged.
- `FETCH_TIMEOUT_EN` undefined: no counter; WAIT holds indefinitely until MFC or RESET; trap_code=2 is never produced.

## Structure
- Shared package `sparc_pkg`:
  - Fetch state enum (IDLE, REQ, WAIT, LOAD, FAULT).
  - trap_code constants: TRAP_NONE, TRAP_MISALIGN, TRAP_IACCESS.
  - The RAM opcode constant for a word read.
- One sub-module, `pc_npc_regs`: holds PC/NPC with reset values 0/4, an advance strobe, and branch select. The FSM, timeout counter and IR capture stay in the top.

## Test plan
- After reset → PC_out=0, NPC_out=4, IR_Enable=0, busy=0; fetch_start with RAM word 0x82002003 at address 0 and MFC after 2 cycles → IR_In=0x82002003, IR_Enable pulses once at cycle 5, PC=4, NPC=8.
- Two fetches, the first with branch_taken=1 and branch_target=0x40 → after fetch 1, PC=4 and NPC=0x40; after fetch 2, PC=0x40 and NPC=0x44 (delayed branch).
- PC forced to 0x6 through a branch_target of 0x6 → the next fetch at PC=0x6 gives fetch_trap for one cycle, trap_code=1, RAM_enable never asserted, PC stays 0x6.
- RESET pulsed in WAIT, followed by a late MFC → all outputs return to reset values; no IR_Enable pulse.
- fetch_start held high continuously with MFC=1 at all times → one instruction every 4 cycles, with PC sequence 0, 4, 8, 12.
- With `FETCH_TIMEOUT_EN` defined and TIMEOUT=15, MFC never asserted → after 15 WAIT cycles, RAM_enable=0, fetch_trap pulses, trap_code=2, PC unchanged.
